// File: rtl/imem_loader.sv
// Instruction-memory loader: builds little-endian 32-bit words from a host byte stream and writes them from word address 0.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  words_loaded
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHK, S_DONE} state_t;
  localparam state_t S_FINISH = S_CHK;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE} state_t;
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t             state, state_nxt;
  logic [7:0]         len_lo;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   word_cnt;
  logic [1:0]         lane_idx;
  logic [ADDR_W-1:0]  addr;
  logic [31:0]        word;
  logic               accept;
  logic               in_range;
  logic               last_word;
  logic               idle_like;
  logic [LEN_W-1:0]   n_hdr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         xsum;
`endif

  assign accept    = byte_valid & byte_ready;
  assign n_hdr     = LEN_W'({byte_data, len_lo});
  // word_cnt counts consumed words so termination still works once words_loaded saturates
  assign in_range  = 32'(words_loaded) < DEPTH;
  assign last_word = (word_cnt == len - LEN_W'(1));
  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign busy      = ~idle_like;
  assign core_hold = ~idle_like;
  assign wr_addr   = addr;
  assign wr_data   = word;

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (accept) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (accept) state_nxt = (n_hdr == '0) ? S_FINISH : S_DATA;
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (accept && lane_idx == 2'd3) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        wr_en     = in_range;
        state_nxt = last_word ? S_FINISH : S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready = 1'b1;
        if (accept) state_nxt = S_DONE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      len_lo       <= '0;
      len          <= '0;
      word_cnt     <= '0;
      lane_idx     <= '0;
      addr         <= '0;
      word         <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xsum         <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state_nxt == S_DONE && state != S_DONE) done <= 1'b1;
      case (state)
        S_IDLE, S_DONE: if (start) begin
          done         <= 1'b0;
          err          <= 1'b0;
          words_loaded <= '0;
          addr         <= '0;
          word_cnt     <= '0;
          lane_idx     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xsum         <= '0;
`endif
        end
        S_LEN_LO: if (accept) len_lo <= byte_data;
        S_LEN_HI: if (accept) len <= n_hdr;
        S_DATA: if (accept) begin
          word[{lane_idx, 3'b000} +: 8] <= byte_data;
          lane_idx <= lane_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xsum <= xsum ^ byte_data;
`endif
        end
        S_WRITE: begin
          word_cnt <= word_cnt + LEN_W'(1);
          // Address parks on the last word rather than wrapping; excess words only flag err
          if (in_range) begin
            words_loaded <= words_loaded + LEN_W'(1);
            if (addr != '1) addr <= addr + ADDR_W'(1);
          end else begin
            err <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: if (accept && byte_data != xsum) err <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=2 so the overflow path is reachable); honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  localparam int unsigned AW = 2;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          err;
  logic [LW-1:0] words_loaded;

  imem_loader #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  logic [7:0]    xs;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      check_eq("ready_in_write", 32'(byte_ready), 32'd0);
      check_eq("hold_in_write", 32'(core_hold), 32'd1);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = byte_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("byte_accept", 32'(ok), 32'd1);
    if (gap) begin
      byte_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      xs = xs ^ b;
      send_byte(b, gap);
    end
  endtask

  task automatic send_header(input logic [15:0] n, input bit gap);
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
  endtask

  task automatic pulse_start;
    xs = 8'h00;
    wa.delete();
    wd.delete();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic end_stream(input bit nonempty, input bit gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xs, gap);
`else
    if (nonempty) begin
      @(posedge clk);
      #1;
    end
`endif
    byte_valid = 1'b0;
  endtask

  task automatic check_basic_writes(input string tag);
    check_eq({tag, "_nwr"}, 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      check_eq({tag, "_a0"}, 32'(wa[0]), 32'd0);
      check_eq({tag, "_d0"}, wd[0], 32'h00A00513);
      check_eq({tag, "_a1"}, 32'(wa[1]), 32'd1);
      check_eq({tag, "_d1"}, wd[1], 32'h00100593);
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_hold"}, 32'(core_hold), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_wl"}, 32'(words_loaded), 32'd2);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check_eq({tag, "_wren"}, 32'(wr_en), 32'd0);
    check_eq({tag, "_addr"}, 32'(wr_addr), 32'd0);
    check_eq({tag, "_data"}, wr_data, 32'd0);
    check_eq({tag, "_hold"}, 32'(core_hold), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_wl"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #12;
    check_all_zero("rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // basic load, valid held high
    check_eq("pre_hold", 32'(core_hold), 32'd0);
    pulse_start();
    check_eq("start_hold", 32'(core_hold), 32'd1);
    check_eq("start_busy", 32'(busy), 32'd1);
    send_header(16'd2, 1'b0);
    send_word(32'h00A00513, 1'b0);
    send_word(32'h00100593, 1'b0);
    end_stream(1'b1, 1'b0);
    check_basic_writes("basic");

    // a byte offered in DONE is not taken
    byte_valid = 1'b1;
    @(negedge clk);
    check_eq("done_ready", 32'(byte_ready), 32'd0);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;

    // backpressure, plus a start while busy
    pulse_start();
    check_eq("bp_done_clr", 32'(done), 32'd0);
    send_header(16'd2, 1'b1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_word(32'h00A00513, 1'b1);
    send_word(32'h00100593, 1'b1);
    end_stream(1'b1, 1'b1);
    check_basic_writes("bp");

    // empty load
    pulse_start();
    send_header(16'd0, 1'b0);
    end_stream(1'b0, 1'b0);
    check_eq("empty_done", 32'(done), 32'd1);
    check_eq("empty_err", 32'(err), 32'd0);
    check_eq("empty_hold", 32'(core_hold), 32'd0);
    check_eq("empty_nwr", 32'(wa.size()), 32'd0);
    check_eq("empty_wl", 32'(words_loaded), 32'd0);

    // overflow: 5 words into a 4-word memory
    pulse_start();
    send_header(16'd5, 1'b0);
    for (int k = 0; k < 5; k++) send_word(32'hA5C30000 + 32'(k * 17), 1'b0);
    end_stream(1'b1, 1'b0);
    check_eq("ovf_nwr", 32'(wa.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < wa.size()) begin
        check_eq("ovf_addr", 32'(wa[k]), 32'(k));
        check_eq("ovf_data", wd[k], 32'hA5C30000 + 32'(k * 17));
      end
    end
    check_eq("ovf_err", 32'(err), 32'd1);
    check_eq("ovf_wl", 32'(words_loaded), 32'd4);
    check_eq("ovf_addr_hold", 32'(wr_addr), 32'd3);
    check_eq("ovf_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    send_header(16'd1, 1'b0);
    send_word(32'h44332211, 1'b0);
    send_byte(8'h44, 1'b0);
    byte_valid = 1'b0;
    check_eq("cks_ok_err", 32'(err), 32'd0);
    check_eq("cks_ok_done", 32'(done), 32'd1);
    pulse_start();
    send_header(16'd1, 1'b0);
    send_word(32'h44332211, 1'b0);
    send_byte(8'h45, 1'b0);
    byte_valid = 1'b0;
    check_eq("cks_bad_err", 32'(err), 32'd1);
    check_eq("cks_bad_done", 32'(done), 32'd1);
`endif

    // reset in the middle of a load
    pulse_start();
    send_header(16'd3, 1'b0);
    send_word(32'h12345678, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    byte_data  = 8'hAD;
    byte_valid = 1'b1;
    reset = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("midrst_ready", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_nwr", 32'(wa.size()), 32'd1);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_wl", 32'(words_loaded), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
